// File: rtl/parity_counter_pkg.sv
// ---------------------------------------------------------------------------
// parity_counter_pkg
//
// Shared definitions for the parity up/down counter family.
//   mode_t     : step-parity encodings as seen on the 2-bit mode port
//   bounds_t   : lowest/highest legal count for a mode, held at MAX_WIDTH
//                bits so one function serves every counter width
//   get_bounds : returns lo/hi for a given mode and counter width
// ---------------------------------------------------------------------------
package parity_counter_pkg;

  // Widest counter the bounds helper can describe.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_EVEN = 2'b01,
    MODE_ODD  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] lo;
    logic [MAX_WIDTH-1:0] hi;
  } bounds_t;

  // lo is 1 only in odd mode. hi is the all-ones value of the counter width,
  // minus one in even mode so that it stays even. Callers compare against a
  // zero-extended count and truncate lo back down to their own width.
  function automatic bounds_t get_bounds(input mode_t mode, input int unsigned width);
    bounds_t              b;
    logic [MAX_WIDTH-1:0] all_ones;
    if (width >= MAX_WIDTH) begin
      all_ones = '1;
    end else begin
      all_ones = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    end
    b.lo = (mode == MODE_ODD) ? MAX_WIDTH'(1) : '0;
    b.hi = (mode == MODE_EVEN) ? (all_ones - MAX_WIDTH'(1)) : all_ones;
    return b;
  endfunction

endpackage

// File: rtl/parity_updown_counter.sv
// ---------------------------------------------------------------------------
// parity_updown_counter
//
// Single-clock up/down counter whose steps can be restricted to even or odd
// values. Supports synchronous load, count enable, wrap-or-saturate at the
// bounds and a one-cycle terminal-count pulse. All outputs are registered.
//
// Parameters
//   WIDTH    counter width in bits (2 .. 64)
//   WRAP     1 = wrap at the bounds, 0 = saturate at the bounds
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active low
//   en       count enable
//   dir      1 = count up, 0 = count down
//   mode     00 all values, 01 even only, 10 odd only, 11 behaves as 00
//   load     synchronous load strobe, wins over en
//   load_val value loaded, LSB forced to match even/odd mode
//   count    current count
//   tc       terminal-count pulse on a wrap or on the first blocked step
//   sat      set while parked at a bound in saturate mode, 0 when WRAP=1
// ---------------------------------------------------------------------------
module parity_updown_counter
  import parity_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sat
);

  mode_t                mode_eff;
  bounds_t              bnd;
  logic [MAX_WIDTH-1:0] count_ext;
  logic                 aligned;
  logic                 at_hi;
  logic                 at_lo;
  logic [WIDTH-1:0]     step;
  logic [WIDTH-1:0]     count_nxt;
  logic                 tc_nxt;
  logic                 sat_nxt;

  // The reserved encoding is folded onto "all values" before anything else
  // looks at the mode.
  assign mode_eff  = (mode == MODE_RSVD) ? MODE_ALL : mode_t'(mode);
  assign bnd       = get_bounds(mode_eff, WIDTH);
  assign count_ext = MAX_WIDTH'(count);
  assign at_hi     = (count_ext == bnd.hi);
  assign at_lo     = (count_ext == bnd.lo);
  assign step      = (mode_eff == MODE_ALL) ? WIDTH'(1) : WIDTH'(2);

  // A count is aligned when its LSB already matches the selected parity.
  // Misaligned counts (left over from a mode change) take a single
  // step of one towards the nearest legal value instead of a full step.
  assign aligned = (mode_eff == MODE_ALL) ||
                   ((mode_eff == MODE_EVEN) && !count[0]) ||
                   ((mode_eff == MODE_ODD)  &&  count[0]);

  // Next-state logic. Load beats enable; with neither, everything holds and
  // tc drops. Any step that really moves the count clears sat, except the
  // inward realign taken in saturate mode, which leaves sat alone.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    sat_nxt   = sat;

    if (load) begin
      count_nxt = load_val;
      if (mode_eff == MODE_EVEN) begin
        count_nxt[0] = 1'b0;
      end else if (mode_eff == MODE_ODD) begin
        count_nxt[0] = 1'b1;
      end
      sat_nxt = 1'b0;
    end else if (en) begin
      if (aligned) begin
        if (dir ? at_hi : at_lo) begin
          if (WRAP) begin
            count_nxt = dir ? WIDTH'(bnd.lo) : WIDTH'(bnd.hi);
            tc_nxt    = 1'b1;
            sat_nxt   = 1'b0;
          end else begin
            tc_nxt  = !sat;
            sat_nxt = 1'b1;
          end
        end else begin
          count_nxt = dir ? (count + step) : (count - step);
          sat_nxt   = 1'b0;
        end
      end else begin
        if (dir ? (&count) : (count == '0)) begin
          if (WRAP) begin
            count_nxt = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
            tc_nxt    = 1'b1;
            sat_nxt   = 1'b0;
          end else begin
            count_nxt = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
          end
        end else begin
          count_nxt = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
          sat_nxt   = 1'b0;
        end
      end
    end

    if (WRAP) begin
      sat_nxt = 1'b0;
    end
  end

  // Single register stage for every output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_parity_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_parity_updown_counter
//
// Directed bench with hand-computed expectations. Three counters share one
// set of inputs: an 8-bit wrapping counter, an 8-bit saturating counter and
// a 2-bit wrapping counter. Each sequence checks only the instance it is
// aimed at.
// ---------------------------------------------------------------------------
module tb_parity_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] w_count;
  logic       w_tc;
  logic       w_sat;
  logic [7:0] s_count;
  logic       s_tc;
  logic       s_sat;
  logic [1:0] n_count;
  logic       n_tc;
  logic       n_sat;

  int vector_count = 0;
  int miscompare_count = 0;

  parity_updown_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(w_count), .tc(w_tc), .sat(w_sat)
  );

  parity_updown_counter #(.WIDTH(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(s_count), .tc(s_tc), .sat(s_sat)
  );

  parity_updown_counter #(.WIDTH(2), .WRAP(1'b1)) u_small (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val[1:0]), .count(n_count), .tc(n_tc), .sat(n_sat)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Drive one set of inputs at the falling edge, then return just after the
  // rising edge that samples them.
  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] lv,
                               input logic e, input logic d, input logic [1:0] m);
    @(negedge clk);
    rst = r;
    load = ld;
    load_val = lv;
    en = e;
    dir = d;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vector_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expectWrap(input string tag, input logic [7:0] c, input logic t, input logic s);
    checkOutput({tag, ".wrap.count"}, 32'(w_count), 32'(c));
    checkOutput({tag, ".wrap.tc"}, 32'(w_tc), 32'(t));
    checkOutput({tag, ".wrap.sat"}, 32'(w_sat), 32'(s));
  endtask

  task automatic expectSat(input string tag, input logic [7:0] c, input logic t, input logic s);
    checkOutput({tag, ".sat.count"}, 32'(s_count), 32'(c));
    checkOutput({tag, ".sat.tc"}, 32'(s_tc), 32'(t));
    checkOutput({tag, ".sat.sat"}, 32'(s_sat), 32'(s));
  endtask

  task automatic expectSmall(input string tag, input logic [1:0] c, input logic t);
    checkOutput({tag, ".small.count"}, 32'(n_count), 32'(c));
    checkOutput({tag, ".small.tc"}, 32'(n_tc), 32'(t));
    checkOutput({tag, ".small.sat"}, 32'(n_sat), 32'(0));
  endtask

  // Directed sequences, in order: reset, even wrap, odd load and wrap,
  // realign, reserved mode with hold, saturation, minimum width.
  initial begin
    logic [1:0] small_cnt [4] = '{2'd2, 2'd0, 2'd2, 2'd0};
    logic       small_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    $display("[TB] start");

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    expectWrap("por", 8'h00, 1'b0, 1'b0);
    expectSat("por", 8'h00, 1'b0, 1'b0);
    expectSmall("por", 2'd0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 2'b00);
    expectWrap("load55", 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 2'b00);
    expectWrap("rst_mid", 8'h00, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 2'b01);
    expectWrap("even_ld", 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    expectWrap("even_dn0", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    expectWrap("even_wrap", 8'hFE, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    expectWrap("even_dn2", 8'hFC, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 2'b10);
    expectWrap("odd_ld", 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10);
    expectWrap("odd_up", 8'h43, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 2'b10);
    expectWrap("odd_ld1", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10);
    expectWrap("odd_wrap_dn", 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10);
    expectWrap("odd_wrap_up", 8'h01, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 2'b00);
    expectWrap("re_ld", 8'h07, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    expectWrap("re_dn", 8'h06, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    expectWrap("re_then", 8'h04, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 2'b00);
    expectSat("reff_ld", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01);
    expectWrap("re_wrap", 8'h00, 1'b1, 1'b0);
    expectSat("re_inward", 8'hFE, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 2'b11);
    expectWrap("m11_ld", 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b11);
    expectWrap("m11_up1", 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b11);
    expectWrap("m11_up2", 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b11);
      expectWrap("hold", 8'h12, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 2'b00);
    expectSat("sat_ld", 8'hFE, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    expectSat("sat_up", 8'hFF, 1'b0, 1'b0);
    expectWrap("wr_up", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    expectSat("sat_first", 8'hFF, 1'b1, 1'b1);
    expectWrap("wr_all", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    expectSat("sat_again", 8'hFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    expectSat("sat_leave", 8'hFE, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 2'b00);
    expectSat("satdn_ld", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    expectSat("satdn_0", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    expectSat("satdn_first", 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    expectSat("satdn_hold", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10);
    expectSat("satdn_inward", 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10);
    expectSat("satdn_up", 8'h03, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    expectSmall("w2_rst", 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01);
      expectSmall($sformatf("w2_even%0d", i), small_cnt[i], small_tc[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
